// File: rtl/drink_vend_if.sv
// Coin/vend/change signal bundle between the front end and drink_vend_ctrl.
// master drives coins and acks; slave is the controller.
interface drink_vend_if #(
  parameter int CREDIT_W = 4
);
  logic                half;
  logic                one;
  logic                cancel;
  logic                restock;
  logic                chg_ack;
  logic                coin_ready;
  logic                coin_rej;
  logic                vend;
  logic                chg_req;
  logic [CREDIT_W-1:0] credit;
  logic                sold_out;

  modport master (
    output half, one, cancel, restock, chg_ack,
    input  coin_ready, coin_rej, vend, chg_req, credit, sold_out
  );

  modport slave (
    input  half, one, cancel, restock, chg_ack,
    output coin_ready, coin_rej, vend, chg_req, credit, sold_out
  );
endinterface

// File: rtl/drink_vend_ctrl.sv
// Drink vending controller: half-unit credit, stock tracking, req/ack change.
// VEND_CANCEL_EN enables refund of collected credit on cancel.
module drink_vend_ctrl #(
  parameter int PRICE      = 4,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input logic         clk,
  input logic         reset,
  drink_vend_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, COLLECT, VEND, CHANGE
  } state_e;

  localparam logic [CREDIT_W:0] PRICE_W =
    (CREDIT_W+1)'(PRICE);
  localparam logic [STOCK_W-1:0] STOCK_RST =
    STOCK_W'(STOCK_INIT);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q, stock_d;
  logic                coin_rej_q, coin_rej_d;

  logic                sold_out;
  logic                coin_ready;
  logic                chg_req;
  logic                sale;
  logic                cancel_hit;
  logic [1:0]          coin_val;
  logic [CREDIT_W:0]   sum;

  assign sold_out   = (stock_q == '0);
  assign coin_ready = ((state_q == IDLE) ||
                       (state_q == COLLECT)) &&
                      !sold_out;
  assign chg_req    = (state_q == CHANGE) &&
                      (credit_q != '0);
  // half is worth 1, one is worth 2: {one,half} is the sum
  assign coin_val   = {bus.one, bus.half};
  assign sum        = {1'b0, credit_q} +
                      {{(CREDIT_W-1){1'b0}}, coin_val};

`ifdef VEND_CANCEL_EN
  assign cancel_hit = bus.cancel &&
                      (state_q == COLLECT);
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
  assign cancel_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      stock_q    <= STOCK_RST;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      stock_q    <= stock_d;
      coin_rej_q <= coin_rej_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    sale     = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (cancel_hit) begin
          // late coin is folded into the refund
          if (coin_ready)
            credit_d = sum[CREDIT_W-1:0];
          state_d = CHANGE;
        end else if (coin_ready &&
                     (coin_val != 2'b00)) begin
          if (sum >= PRICE_W) begin
            credit_d = CREDIT_W'(sum - PRICE_W);
            sale     = 1'b1;
            state_d  = VEND;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end
        end
      end
      VEND: begin
        state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (chg_req && bus.chg_ack) begin
          credit_d = credit_q - 1'b1;
          if (credit_q == CREDIT_W'(1))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.restock)
      stock_d = STOCK_RST;
    else if (sale)
      stock_d = stock_q - 1'b1;
    else
      stock_d = stock_q;

    coin_rej_d = (bus.half || bus.one) &&
                 !coin_ready;
  end

  always_comb begin
    bus.coin_ready = coin_ready;
    bus.coin_rej   = coin_rej_q;
    bus.vend       = (state_q == VEND);
    bus.chg_req    = chg_req;
    bus.credit     = credit_q;
    bus.sold_out   = sold_out;
  end

endmodule

// File: tb/tb_drink_vend_ctrl.sv
// Directed bench for drink_vend_ctrl: PRICE=4 main unit plus a
// single-stock unit for sold-out and restock corners.
module tb_drink_vend_ctrl;

  logic clk;
  logic rst0_n;
  logic rst1_n;

  drink_vend_if #(.CREDIT_W(4)) bus0 ();
  drink_vend_if #(.CREDIT_W(4)) bus1 ();

  drink_vend_ctrl #(
    .PRICE(4), .CREDIT_W(4),
    .STOCK_W(4), .STOCK_INIT(8)
  ) dut0 (
    .clk(clk), .reset(rst0_n), .bus(bus0)
  );

  drink_vend_ctrl #(
    .PRICE(4), .CREDIT_W(4),
    .STOCK_W(4), .STOCK_INIT(1)
  ) dut1 (
    .clk(clk), .reset(rst1_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic h, o, a, c, r;
    logic ev, ec;
    int   cr;
    logic rdy, rej, so;
  } vec_t;

  vec_t tbl[$];
  int   n_pass;
  int   n_tot;

  function automatic vec_t mk(
    logic h, logic o, logic a, logic c, logic r,
    logic ev, logic ec, int cr,
    logic rdy, logic rej, logic so);
    vec_t v;
    v.h = h; v.o = o; v.a = a; v.c = c; v.r = r;
    v.ev = ev; v.ec = ec; v.cr = cr;
    v.rdy = rdy; v.rej = rej; v.so = so;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
  endtask

  task automatic drive(bit which, logic h, logic o,
                       logic a, logic c, logic r);
    if (!which) begin
      bus0.half = h; bus0.one = o; bus0.chg_ack = a;
      bus0.cancel = c; bus0.restock = r;
    end else begin
      bus1.half = h; bus1.one = o; bus1.chg_ack = a;
      bus1.cancel = c; bus1.restock = r;
    end
  endtask

  task automatic step(bit which, logic h, logic o,
                      logic a, logic c, logic r);
    drive(which, h, o, a, c, r);
    @(posedge clk);
    #1;
    drive(which, 0, 0, 0, 0, 0);
  endtask

  task automatic chk0(string nm, logic ev, logic ec,
                      int cr, logic rdy, logic rej,
                      logic so);
    chk({nm, ".vend"},       int'(bus0.vend), int'(ev));
    chk({nm, ".chg_req"},    int'(bus0.chg_req), int'(ec));
    chk({nm, ".credit"},     int'(bus0.credit), cr);
    chk({nm, ".coin_ready"}, int'(bus0.coin_ready), int'(rdy));
    chk({nm, ".coin_rej"},   int'(bus0.coin_rej), int'(rej));
    chk({nm, ".sold_out"},   int'(bus0.sold_out), int'(so));
  endtask

  task automatic chk1(string nm, logic ev, int cr,
                      logic rdy, logic rej, logic so);
    chk({nm, ".vend"},       int'(bus1.vend), int'(ev));
    chk({nm, ".credit"},     int'(bus1.credit), cr);
    chk({nm, ".coin_ready"}, int'(bus1.coin_ready), int'(rdy));
    chk({nm, ".coin_rej"},   int'(bus1.coin_rej), int'(rej));
    chk({nm, ".sold_out"},   int'(bus1.sold_out), int'(so));
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    //        h  o  a  c  r   ev ec cr rdy rej so
    // test 1: half, half, one
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // test 2: one, half, one -> change of 1
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    // test 3: credit 3 then half+one, stalled change
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    // coin during CHANGE is rejected
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    // coin during VEND is rejected
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // ack without request is ignored
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    // cancel with credit 3
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
`ifdef VEND_CANCEL_EN
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    // coin together with cancel is refunded too
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
`else
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
`endif

    #12;
    chk0("reset0", 0, 0, 0, 1, 0, 0);
    chk1("reset1", 0, 0, 1, 0, 0);
    #5;
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(0, tbl[i].h, tbl[i].o, tbl[i].a,
           tbl[i].c, tbl[i].r);
      chk0($sformatf("vec%0d", i), tbl[i].ev,
           tbl[i].ec, tbl[i].cr, tbl[i].rdy,
           tbl[i].rej, tbl[i].so);
    end

    // reset asserted in the middle of CHANGE
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk0("mid.vend", 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk0("mid.change", 0, 1, 1, 0, 0, 0);
    #2;
    rst0_n = 1'b0;
    #1;
    chk0("mid.reset", 0, 0, 0, 1, 0, 0);
    #2;
    rst0_n = 1'b1;

    // single-stock unit: sell out, reject, restock
    step(1, 0, 1, 0, 0, 0);
    chk1("s1.coin", 0, 2, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk1("s1.sale", 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk1("s1.empty", 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    chk1("s1.rej", 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    chk1("s1.restock", 0, 0, 1, 0, 0);
    // restock on the selling edge wins over the decrement
    step(1, 0, 1, 0, 0, 0);
    chk1("s1.coin2", 0, 2, 1, 0, 0);
    step(1, 0, 1, 0, 0, 1);
    chk1("s1.sale_rs", 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk1("s1.after_rs", 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
